// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential fetch, branch/trap redirects with a
// one-entry pending register for redirects that arrive while the pipeline is stalled.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              INST_BYTES   = 4,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_en,
  input  logic             pc_ready,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_valid,
  input  logic             halt_req,
  output logic [XLEN-1:0]  pc_output,
  output logic             pc_valid,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] INST_STEP  = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pend_tgt_q, pend_tgt_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_trap_q, pend_trap_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             advance;
  logic             mis_req;
  logic             req_valid;
  logic             req_trap;
  logic             req_take;
  logic [XLEN-1:0]  req_tgt;

  assign pc_valid     = (state_q != ST_HALT);
  assign advance      = pc_en & pc_ready & pc_valid;
  assign pc_output    = pc_q;
  assign misalign_err = mis_q;
  assign fetch_count  = cnt_q;
  assign state_o      = state_q;

  // A misaligned redirect behaves like a trap: it targets TRAP_VECTOR and is
  // protected from being overwritten by later plain redirects while pending.
  assign mis_req   = redirect_valid & ~trap_valid & ((redirect_target & ALIGN_MASK) != '0);
  assign req_valid = trap_valid | redirect_valid;
  assign req_trap  = trap_valid | mis_req;
  assign req_tgt   = req_trap ? TRAP_VECTOR : redirect_target;
  assign req_take  = req_valid & (trap_valid | ~pend_valid_q | ~pend_trap_q);

  always_comb begin
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    pend_tgt_d   = pend_tgt_q;
    pend_valid_d = pend_valid_q;
    pend_trap_d  = pend_trap_q;
    mis_d        = 1'b0;

    if (advance) begin
      if (req_valid)         pc_d = req_tgt;
      else if (pend_valid_q) pc_d = pend_tgt_q;
      else                   pc_d = pc_q + INST_STEP;
      cnt_d        = cnt_q + CNT_W'(1);
      pend_valid_d = 1'b0;
      pend_trap_d  = 1'b0;
      pend_tgt_d   = '0;
      mis_d        = mis_req;
    end else if (req_take) begin
      pend_valid_d = 1'b1;
      pend_trap_d  = req_trap;
      pend_tgt_d   = req_tgt;
      mis_d        = mis_req;
    end

    if (halt_req)          state_d = ST_HALT;
    else if (pend_valid_d) state_d = ST_PEND;
    else                   state_d = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_VECTOR;
      cnt_q        <= '0;
      pend_tgt_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_trap_q  <= 1'b0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      pend_tgt_q   <= pend_tgt_d;
      pend_valid_q <= pend_valid_d;
      pend_trap_q  <= pend_trap_d;
      mis_q        <= mis_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a table of per-cycle input/expected-output records
// followed by a hand-written halt sequence of variable length.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_en;
  logic        pc_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic        halt_req;
  logic [31:0] pc_output;
  logic        pc_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk            (clk),
    .reset          (reset),
    .pc_en          (pc_en),
    .pc_ready       (pc_ready),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .trap_valid     (trap_valid),
    .halt_req       (halt_req),
    .pc_output      (pc_output),
    .pc_valid       (pc_valid),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count),
    .state_o        (state_o)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        rdy;
    logic        rv;
    logic [31:0] tgt;
    logic        trap;
    logic        halt;
    logic [31:0] e_pc;
    logic        e_vld;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic en, input logic rdy, input logic rv,
                     input logic [31:0] tgt, input logic trap, input logic halt,
                     input logic [31:0] e_pc, input logic e_vld, input logic e_mis,
                     input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.en = en; v.rdy = rdy; v.rv = rv; v.tgt = tgt; v.trap = trap;
    v.halt = halt; v.e_pc = e_pc; v.e_vld = e_vld; v.e_mis = e_mis; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic rst, input logic en, input logic rdy, input logic rv,
                       input logic [31:0] tgt, input logic trap, input logic halt);
    @(negedge clk);
    reset = rst; pc_en = en; pc_ready = rdy; redirect_valid = rv;
    redirect_target = tgt; trap_valid = trap; halt_req = halt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e_pc, input logic e_vld,
                            input logic e_mis, input logic [31:0] e_cnt);
    check({tag, ".pc"},  pc_output,           e_pc);
    check({tag, ".vld"}, {31'd0, pc_valid},    {31'd0, e_vld});
    check({tag, ".mis"}, {31'd0, misalign_err}, {31'd0, e_mis});
    check({tag, ".cnt"}, fetch_count,         e_cnt);
  endtask

  initial begin
    int hold_cycles;
    reset = 1'b1; pc_en = 1'b0; pc_ready = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; trap_valid = 1'b0; halt_req = 1'b0;

    //  rst en rdy rv  tgt           trap halt   pc            vld mis cnt
    add(1, 1, 1, 0, 32'h0,         0, 0,  32'h0,         1, 0, 0);   // reset
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h4,         1, 0, 1);   // sequential run
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h8,         1, 0, 2);
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'hC,         1, 0, 3);
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h10,        1, 0, 4);
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h14,        1, 0, 5);
    add(0, 0, 1, 1, 32'h200,       0, 0,  32'h14,        1, 0, 5);   // stalled redirect
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h200,       1, 0, 6);
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h204,       1, 0, 7);
    add(0, 1, 1, 1, 32'h202,       0, 0,  32'h100,       1, 1, 8);   // misaligned
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h104,       1, 0, 9);
    add(0, 0, 1, 0, 32'h0,         1, 0,  32'h104,       1, 0, 9);   // pending trap
    add(0, 0, 1, 1, 32'h300,       0, 0,  32'h104,       1, 0, 9);   // redirect ignored
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h100,       1, 0, 10);
    add(0, 1, 0, 0, 32'h0,         0, 0,  32'h100,       1, 0, 10);  // memory not ready
    add(0, 1, 1, 0, 32'h0,         0, 1,  32'h104,       0, 0, 11);  // halt, last advance
    add(0, 1, 1, 0, 32'h0,         0, 1,  32'h104,       0, 0, 11);
    add(0, 1, 1, 1, 32'h400,       0, 1,  32'h104,       0, 0, 11);  // latched in halt
    add(0, 0, 1, 0, 32'h0,         0, 0,  32'h104,       1, 0, 11);  // exit to pend
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h400,       1, 0, 12);
    add(0, 1, 1, 0, 32'h0,         0, 1,  32'h404,       0, 0, 13);
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h404,       1, 0, 13);  // exit to run
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h408,       1, 0, 14);
    add(0, 0, 1, 1, 32'h500,       0, 0,  32'h408,       1, 0, 14);  // pend then reset
    add(1, 0, 0, 0, 32'h0,         0, 0,  32'h0,         1, 0, 0);
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h4,         1, 0, 1);
    add(0, 1, 1, 1, 32'h202,       1, 0,  32'h100,       1, 0, 2);   // trap beats redirect
    add(0, 1, 1, 1, 32'hFFFF_FFF8, 0, 0,  32'hFFFF_FFF8, 1, 0, 3);
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'hFFFF_FFFC, 1, 0, 4);
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h0,         1, 0, 5);   // wrap
    add(0, 0, 1, 1, 32'h600,       0, 0,  32'h0,         1, 0, 5);
    add(0, 0, 1, 1, 32'h700,       0, 0,  32'h0,         1, 0, 5);   // overwrite redirect
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h700,       1, 0, 6);
    add(0, 0, 1, 1, 32'h702,       0, 0,  32'h700,       1, 1, 6);   // stalled misalign
    add(0, 0, 1, 0, 32'h0,         0, 0,  32'h700,       1, 0, 6);
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h100,       1, 0, 7);
    add(0, 0, 1, 0, 32'h0,         0, 1,  32'h100,       0, 0, 7);   // halt then reset
    add(1, 0, 0, 0, 32'h0,         0, 1,  32'h0,         1, 0, 0);
    add(0, 1, 1, 0, 32'h0,         0, 0,  32'h4,         1, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].rdy, vecs[i].rv, vecs[i].tgt,
            vecs[i].trap, vecs[i].halt);
      check_outs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_vld,
                 vecs[i].e_mis, vecs[i].e_cnt);
    end

    // Halt held for a variable number of cycles: PC and count must stay frozen.
    drive(0, 1, 1, 0, 32'h0, 0, 1);
    check_outs("halt_enter", 32'h8, 1'b0, 1'b0, 32'd2);
    hold_cycles = $urandom_range(3, 6);
    for (int k = 0; k < hold_cycles; k++) begin
      drive(0, 1, 1, 0, 32'h0, 0, 1);
      check_outs($sformatf("halt_hold%0d", k), 32'h8, 1'b0, 1'b0, 32'd2);
    end
    drive(0, 1, 1, 0, 32'h0, 0, 0);
    check_outs("halt_exit", 32'h8, 1'b1, 1'b0, 32'd2);
    drive(0, 1, 1, 0, 32'h0, 0, 0);
    check_outs("halt_resume", 32'hC, 1'b1, 1'b0, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, width of PC and targets.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, PC value after reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100, target for traps and misaligned redirects.
REQ-004 Parameter INST_BYTES, default 4 (power of two, >=1), sequential increment and alignment unit.
REQ-005 Parameter CNT_W, default 32, width of fetch counter.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 pc_en  in  1  hazard-detect enable; 1 = pipeline may advance, 0 = stall.
REQ-009 pc_ready  in  1  instruction memory accepts current pc_output.
REQ-010 redirect_valid  in  1  branch/jump redirect request, single-cycle.
REQ-011 redirect_target  in  XLEN  redirect destination.
REQ-012 trap_valid  in  1  trap request, single-cycle; destination TRAP_VECTOR.
REQ-013 halt_req  in  1  level; 1 = stop fetching.
REQ-014 pc_output  out  XLEN  current fetch PC.
REQ-015 pc_valid  out  1  pc_output is a valid fetch request.
REQ-016 misalign_err  out  1  one-cycle pulse: misaligned redirect_target received.
REQ-017 fetch_count  out  CNT_W  number of accepted fetches.

Function
REQ-018 States SHALL be RUN, PEND (redirect held), HALT; state encoding is internal.
REQ-019 advance = pc_en & pc_ready & pc_valid; pc_output, fetch_count update only on advance or redirect load.
REQ-020 pc_valid SHALL be 1 in RUN and PEND, 0 in HALT.
REQ-021 Next-PC priority on advance: trap_valid > redirect_valid > pending target > pc_output + INST_BYTES.
REQ-022 Sequential increment SHALL wrap modulo 2^XLEN (e.g. 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 Redirect misaligned when redirect_target mod INST_BYTES != 0; effective target becomes TRAP_VECTOR and misalign_err pulses in the cycle after redirect_valid sampled; never for INST_BYTES=1.
REQ-024 trap_valid or redirect_valid without advance: effective target latched into pending register, state -> PEND; pc_output held.
REQ-025 In PEND, new trap_valid SHALL overwrite pending target; new redirect_valid SHALL overwrite only if pending entry is not a trap.
REQ-026 trap_valid and redirect_valid same cycle: trap wins; redirect discarded, no misalign_err.
REQ-027 PEND -> RUN on first advance; pc_output <= pending target (or newer same-cycle request per REQ-021); pending cleared.
REQ-028 halt_req=1 in any state -> HALT next cycle; pending entry retained; redirects during HALT latched per REQ-024/025.
REQ-029 HALT exit when halt_req=0: -> PEND if entry pending, else RUN; pc_output unchanged on exit.
REQ-030 fetch_count +1 per advance, wraps modulo 2^CNT_W; not incremented in HALT.
REQ-031 Sequencing is single-cycle latency: request in cycle N with advance -> new pc_output visible cycle N+1.

Reset
REQ-032 reset=1 at clock edge overrides all inputs including pc_en (unlike gated enable): pc_output=RESET_VECTOR, pc_valid=1 (state RUN), pending cleared, misalign_err=0, fetch_count=0.
REQ-033 reset mid-PEND or mid-HALT SHALL discard pending redirect and return to RUN.
REQ-034 First advance after reset presents RESET_VECTOR+INST_BYTES next.

Verification
REQ-035 Reset, pc_en=pc_ready=1 five cycles -> pc_output 0,4,8,C,10; fetch_count=5.
REQ-036 pc_en=0, redirect_valid to 0x200 -> pc held, PEND; pc_en=1 -> pc_output=0x200, then 0x204.
REQ-037 redirect_target=0x202 -> misalign_err pulse one cycle, pc_output=0x100.
REQ-038 PEND trap then redirect to 0x300 while stalled -> on release pc_output=0x100.
REQ-039 halt_req=1 -> pc_valid=0, count frozen; release -> resumes at held PC; reset with pc_en=0 -> pc_output=RESET_VECTOR.
REQ-040 Start at 0xFFFF_FFF8 (via redirect) -> 0xFFFF_FFFC, 0x0000_0000.
